fixed_point_complex_accumulator: RTL and testbench



---
 rtl/fixed_point_accum_pkg.sv | 14 +
 rtl/fixed_point_comb_complex_adder.sv | 17 +
 rtl/fixed_point_complex_accumulator.sv | 88 ++++++++
 tb/tb_fixed_point_complex_accumulator.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fixed_point_accum_pkg.sv
// Shared types and helpers for the fixed-point complex accumulator family.
package fixed_point_accum_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } accum_state_e;

  // Batch counter width; sized for values 0..len so the terminal compare never overflows.
  function automatic int count_w(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/fixed_point_comb_complex_adder.sv
// Combinational n-bit wrapping complex adder (also used by the butterfly stage).
module fixed_point_comb_complex_adder #(
  parameter int DATA_W = 32
) (
  input  logic signed [DATA_W-1:0] a_r,
  input  logic signed [DATA_W-1:0] a_c,
  input  logic signed [DATA_W-1:0] b_r,
  input  logic signed [DATA_W-1:0] b_c,
  output logic signed [DATA_W-1:0] s_r,
  output logic signed [DATA_W-1:0] s_c
);

  // Same-width two's-complement add: carry out is dropped, giving modulo 2^n wrap.
  assign s_r = a_r + b_r;
  assign s_c = a_c + b_c;

endmodule

// File: rtl/fixed_point_complex_accumulator.sv
// Streaming complex accumulator: sums LEN complex products, then offers the sum
// as a single val/rdy transaction before starting the next batch.
module fixed_point_complex_accumulator
  import fixed_point_accum_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16,
  parameter int LEN    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     recv_val,
  output logic                     recv_rdy,
  input  logic signed [DATA_W-1:0] in_r,
  input  logic signed [DATA_W-1:0] in_c,
  output logic                     send_val,
  input  logic                     send_rdy,
  output logic signed [DATA_W-1:0] out_r,
  output logic signed [DATA_W-1:0] out_c
);

  localparam int CNT_W = count_w(LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

  accum_state_e state, state_nxt;

  logic signed [DATA_W-1:0] acc_r, acc_c;
  logic signed [DATA_W-1:0] sum_r, sum_c;
  logic [CNT_W-1:0]         count;
  logic                     recv_hs;
  logic                     last_in;

  fixed_point_comb_complex_adder #(
    .DATA_W(DATA_W)
  ) u_adder (
    .a_r(acc_r),
    .a_c(acc_c),
    .b_r(in_r),
    .b_c(in_c),
    .s_r(sum_r),
    .s_c(sum_c)
  );

  // Handshake flags depend only on registered state, never on send_rdy.
  assign recv_rdy = (state == ACCUM);
  assign send_val = (state == DONE);
  assign recv_hs  = recv_val && recv_rdy;
  assign last_in  = (count == LAST_CNT);

  assign out_r = acc_r;
  assign out_c = acc_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (recv_hs && last_in) state_nxt = DONE;
      DONE:    if (send_rdy)           state_nxt = ACCUM;
      default:                         state_nxt = ACCUM;
    endcase
  end

  // The accumulator also serves as the output holding register throughout DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r <= '0;
      acc_c <= '0;
      count <= '0;
    end else if (state == ACCUM) begin
      if (recv_hs) begin
        acc_r <= sum_r;
        acc_c <= sum_c;
        count <= last_in ? '0 : count + CNT_W'(1);
      end
    end else if (send_rdy) begin
      acc_r <= '0;
      acc_c <= '0;
    end
  end

endmodule

// File: tb/tb_fixed_point_complex_accumulator.sv
// Self-checking bench for fixed_point_complex_accumulator at LEN = 4, 2 and 1.
module tb_fixed_point_complex_accumulator;

  localparam int NI = 3;

  logic        clk;
  logic        reset;
  logic        rv [NI];
  logic        rr [NI];
  logic        sv [NI];
  logic        sr [NI];
  logic [31:0] ir [NI];
  logic [31:0] ic [NI];
  logic [31:0] o_r [NI];
  logic [31:0] o_c [NI];

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: batch progress per instance
  bit        m_done [NI];
  bit [31:0] m_r [NI];
  bit [31:0] m_c [NI];
  int        m_cnt [NI];

  function automatic int lens(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 2 : 1);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    fixed_point_complex_accumulator #(
      .DATA_W(32),
      .FRAC_W(16),
      .LEN((g == 0) ? 4 : ((g == 1) ? 2 : 1))
    ) u_dut (
      .clk(clk),
      .reset(reset),
      .recv_val(rv[g]),
      .recv_rdy(rr[g]),
      .in_r(ir[g]),
      .in_c(ic[g]),
      .send_val(sv[g]),
      .send_rdy(sr[g]),
      .out_r(o_r[g]),
      .out_c(o_c[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_done[i] = 1'b0;
      m_r[i] = '0;
      m_c[i] = '0;
      m_cnt[i] = 0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < NI; i++) begin
      rv[i] = 1'b1;
      sr[i] = 1'b0;
      ir[i] = $urandom;
      ic[i] = $urandom;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < NI; i++) begin
      rv[i] = 1'b0;
    end
    model_reset();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("reset_rdy%0d", i), 32'(rr[i]), 32'd1);
      chk($sformatf("reset_val%0d", i), 32'(sv[i]), 32'd0);
      chk($sformatf("reset_out_r%0d", i), o_r[i], 32'd0);
      chk($sformatf("reset_out_c%0d", i), o_c[i], 32'd0);
    end
  endtask

  // Drive one cycle on instance i, advance the model, then compare after the edge.
  task automatic cycle(input int i, input logic v, input logic [31:0] r,
                       input logic [31:0] c, input logic s);
    rv[i] = v;
    ir[i] = r;
    ic[i] = c;
    sr[i] = s;
    if (!m_done[i]) begin
      if (v) begin
        m_r[i] += r;
        m_c[i] += c;
        m_cnt[i]++;
        if (m_cnt[i] == lens(i)) begin
          m_done[i] = 1'b1;
          m_cnt[i] = 0;
        end
      end
    end else if (s) begin
      m_done[i] = 1'b0;
      m_r[i] = '0;
      m_c[i] = '0;
    end
    @(posedge clk); #1;
    rv[i] = 1'b0;
    sr[i] = 1'b0;
    chk($sformatf("rdy%0d", i), 32'(rr[i]), 32'(!m_done[i]));
    chk($sformatf("val%0d", i), 32'(sv[i]), 32'(m_done[i]));
    if (m_done[i]) begin
      chk($sformatf("sum_r%0d", i), o_r[i], m_r[i]);
      chk($sformatf("sum_c%0d", i), o_c[i], m_c[i]);
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < NI; i++) begin
      rv[i] = 1'b0;
      sr[i] = 1'b0;
      ir[i] = '0;
      ic[i] = '0;
    end
    model_reset();
    do_reset();

    // Basic Q16.16 batch, consumer always ready
    cycle(0, 1'b1, 32'h0001_0000, 32'h0000_0000, 1'b1);
    cycle(0, 1'b1, 32'h0000_8000, 32'hFFFF_8000, 1'b1);
    cycle(0, 1'b1, 32'h0000_4000, 32'h0000_4000, 1'b1);
    chk("basic_no_early_val", 32'(sv[0]), 32'd0);
    cycle(0, 1'b1, 32'hFFFF_0000, 32'h0002_0000, 1'b1);
    chk("basic_val", 32'(sv[0]), 32'd1);
    chk("basic_out_r", o_r[0], 32'h0000_C000);
    chk("basic_out_c", o_c[0], 32'h0001_C000);
    cycle(0, 1'b0, 32'h0, 32'h0, 1'b1);
    chk("basic_val_one_cycle", 32'(sv[0]), 32'd0);

    // Back-pressure: DONE held, output stable, inputs ignored
    cycle(0, 1'b1, 32'h0001_0000, 32'h0000_0000, 1'b0);
    cycle(0, 1'b1, 32'h0000_8000, 32'hFFFF_8000, 1'b0);
    cycle(0, 1'b1, 32'h0000_4000, 32'h0000_4000, 1'b0);
    cycle(0, 1'b1, 32'hFFFF_0000, 32'h0002_0000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cycle(0, 1'b1, $urandom, $urandom, 1'b0);
      chk("hold_out_r", o_r[0], 32'h0000_C000);
      chk("hold_out_c", o_c[0], 32'h0001_C000);
      chk("hold_rdy", 32'(rr[0]), 32'd0);
    end
    cycle(0, 1'b0, 32'h0, 32'h0, 1'b1);
    chk("drain_rdy", 32'(rr[0]), 32'd1);
    chk("drain_acc_r", o_r[0], 32'd0);
    chk("drain_acc_c", o_c[0], 32'd0);

    // Gaps inside a batch
    begin
      bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      for (int k = 0; k < 7; k++) begin
        cycle(0, pat[k], 32'h0001_0000, 32'h0, 1'b1);
        if (k < 6) chk("gap_no_early_val", 32'(sv[0]), 32'd0);
      end
    end
    chk("gap_out_r", o_r[0], 32'h0004_0000);
    chk("gap_out_c", o_c[0], 32'h0000_0000);
    cycle(0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Wrap-around at LEN = 2
    cycle(1, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
    cycle(1, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
    chk("wrap_out_r", o_r[1], 32'hFFFF_FFFE);
    chk("wrap_out_c", o_c[1], 32'h0000_0000);
    cycle(1, 1'b0, 32'h0, 32'h0, 1'b1);

    // Reset aborts a partial batch
    cycle(0, 1'b1, 32'h0005_0000, 32'h0007_0000, 1'b1);
    cycle(0, 1'b1, 32'h0005_0000, 32'h0007_0000, 1'b1);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1'b1, 32'h0001_0000, 32'h0001_0000, 1'b1);
      chk("abort_no_val", 32'(sv[0]), 32'd0);
    end
    cycle(0, 1'b1, 32'h0001_0000, 32'h0001_0000, 1'b1);
    chk("abort_out_r", o_r[0], 32'h0004_0000);
    chk("abort_out_c", o_c[0], 32'h0004_0000);
    cycle(0, 1'b0, 32'h0, 32'h0, 1'b1);

    // LEN = 1 back-to-back: producer holds (7,9) until accepted
    cycle(2, 1'b1, 32'd3, 32'd5, 1'b1);
    chk("len1_a_r", o_r[2], 32'd3);
    chk("len1_a_c", o_c[2], 32'd5);
    chk("len1_rdy0", 32'(rr[2]), 32'd0);
    cycle(2, 1'b1, 32'd7, 32'd9, 1'b1);
    chk("len1_rdy1", 32'(rr[2]), 32'd1);
    cycle(2, 1'b1, 32'd7, 32'd9, 1'b1);
    chk("len1_b_r", o_r[2], 32'd7);
    chk("len1_b_c", o_c[2], 32'd9);
    chk("len1_rdy2", 32'(rr[2]), 32'd0);
    cycle(2, 1'b0, 32'h0, 32'h0, 1'b1);

    // Randomized traffic against the model on every instance
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < 300; k++) begin
        cycle(i, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
